// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-cycle data memory between the core
// load/store path (port c) and a DMA/debug loader (port d).
// The core normally wins; a saturating streak counter forces a DMA win
// after MAX_BURST consecutive core grants while DMA is waiting.
// Optional statistics counters are compiled in with DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [15:0]       dma_force_cnt
`endif
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic [3:0]        streak_q, streak_d;
  logic              c_win, d_win;
  logic              c_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;

  // Winner selection; nothing is granted while reset is held.
  always_comb begin
    c_win = reset & c_req & (~d_req | (streak_q < BURST_LIM));
    d_win = reset & d_req & ~c_win;
  end

  assign c_gnt      = c_win;
  assign d_gnt      = d_win;
  assign core_stall = reset & c_req & ~c_win;

  // Memory port follows the winner, idles at all-zero without a grant.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (c_win) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = c_we;
      mem_re    = ~c_we;
    end else if (d_win) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_we    = d_we;
      mem_re    = ~d_we;
    end
  end

  // Streak of core wins over a waiting DMA; clears once DMA wins or stops asking.
  always_comb begin
    streak_d = streak_q;
    if (d_win || !d_req) begin
      streak_d = 4'd0;
    end else if (c_win && (streak_q < BURST_LIM)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // Read return: capture memory data for the read winner, valid for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= c_win & ~c_we;
      d_rvalid_q <= d_win & ~d_we;
      if (c_win && !c_we) begin
        c_rdata_q <= mem_rdata;
      end
      if (d_win && !d_we) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_cnt_q;
  logic [15:0] dma_force_cnt_q;

  // Contention cycles (wrapping) and forced DMA wins (saturating).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt_q  <= 32'd0;
      dma_force_cnt_q <= 16'd0;
    end else begin
      if (c_req && d_req) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
      if (d_win && c_req && (dma_force_cnt_q != 16'hFFFF)) begin
        dma_force_cnt_q <= dma_force_cnt_q + 16'd1;
      end
    end
  end

  assign conflict_cnt  = conflict_cnt_q;
  assign dma_force_cnt = dma_force_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver issues one stimulus per cycle
// and pushes the expected responses; a monitor pops and compares them.
module tb_dmem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0, mem_rdata = '0;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we, mem_re, core_stall;
  logic [DW-1:0] c_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   conflict_cnt;
  logic [15:0]   dma_force_cnt;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .core_stall(core_stall)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .dma_force_cnt(dma_force_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            rst;
    bit            cg, dg, we, re, stall;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    longint        conf;
    longint        frc;
  } rec_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  rec_t cq[$];
  rd_t  crq[$];
  rd_t  drq[$];

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  // Reference model state: streak of core wins over a waiting DMA, stats.
  int     streak = 0;
  longint m_conf = 0;
  longint m_frc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // One stimulus cycle: apply inputs at the falling edge, push expectations.
  task automatic drive(input bit rst, input bit cr, input bit cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input bit dr, input bit dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input logic [DW-1:0] rd);
    rec_t r;
    bit   cwin, dwin;
    @(negedge clk);
    cyc++;
    reset = rst; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; mem_rdata = rd;
    r = '{cyc: cyc, rst: !rst, cg: 0, dg: 0, we: 0, re: 0, stall: 0,
          addr: '0, wdata: '0, conf: 0, frc: 0};
    if (!rst) begin
      streak = 0; m_conf = 0; m_frc = 0;
      crq.delete(); drq.delete();
    end else begin
      // Core wins unless DMA has waited through MAXB consecutive core grants.
      cwin = cr && (!dr || streak < MAXB);
      dwin = dr && !cwin;
      r.cg = cwin; r.dg = dwin; r.stall = cr && !cwin;
      r.conf = m_conf; r.frc = m_frc;
      if (cwin) begin
        r.addr = ca; r.wdata = cd; r.we = cw; r.re = !cw;
        if (!cw) crq.push_back('{due: cyc + 1, data: rd});
      end else if (dwin) begin
        r.addr = da; r.wdata = dd; r.we = dw; r.re = !dw;
        if (!dw) drq.push_back('{due: cyc + 1, data: rd});
      end
      if (cr && dr) m_conf = (m_conf + 1) % 64'h1_0000_0000;
      if (dwin && cr && m_frc < 16'hFFFF) m_frc++;
      if (dwin || !dr) streak = 0;
      else if (cwin) streak = (streak + 1 > MAXB) ? MAXB : streak + 1;
    end
    cq.push_back(r);
  endtask

  // Monitor: compares DUT outputs against the popped expectations each cycle.
  initial begin : monitor
    rec_t          r;
    logic [DW-1:0] last_c, last_d;
    last_c = '0; last_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() != 0) begin
        r = cq.pop_front();
        chk("c_gnt", 64'(c_gnt), 64'(r.cg));
        chk("d_gnt", 64'(d_gnt), 64'(r.dg));
        chk("core_stall", 64'(core_stall), 64'(r.stall));
        chk("mem_we", 64'(mem_we), 64'(r.we));
        chk("mem_re", 64'(mem_re), 64'(r.re));
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_wdata", mem_wdata, r.wdata);
        if (r.rst) begin
          last_c = '0; last_d = '0;
        end
        if (crq.size() != 0 && crq[0].due == r.cyc) begin
          chk("c_rvalid", 64'(c_rvalid), 64'd1);
          chk("c_rdata", c_rdata, crq[0].data);
          last_c = crq[0].data;
          void'(crq.pop_front());
        end else begin
          chk("c_rvalid_idle", 64'(c_rvalid), 64'd0);
          chk("c_rdata_hold", c_rdata, last_c);
        end
        if (drq.size() != 0 && drq[0].due == r.cyc) begin
          chk("d_rvalid", 64'(d_rvalid), 64'd1);
          chk("d_rdata", d_rdata, drq[0].data);
          last_d = drq[0].data;
          void'(drq.pop_front());
        end else begin
          chk("d_rvalid_idle", 64'(d_rvalid), 64'd0);
          chk("d_rdata_hold", d_rdata, last_d);
        end
`ifdef DMEM_ARB_STATS_EN
        chk("conflict_cnt", 64'(conflict_cnt), 64'(r.conf));
        chk("dma_force_cnt", 64'(dma_force_cnt), 64'(r.frc));
`endif
        if (c_gnt || d_gnt)
          $display("cyc=%0d grant=%s we=%0b addr=0x%0h", r.cyc, c_gnt ? "C" : "D",
                   mem_we, mem_addr);
      end
    end
  end

  initial begin : stimulus
    // Reset held with both requesting: nothing may be granted.
    repeat (3) drive(0, 1, 0, 64'h10, 0, 1, 0, 64'h20, 0, 64'h5);
    // Directed core read at 0x40 returning 0xDEAD (first cycle after release).
    drive(1, 1, 0, 64'h40, 0, 0, 0, 0, 0, 64'hDEAD);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h2);
    // Ten cycles of full contention: C,C,C,C,D,C,C,C,C,D.
    for (int i = 0; i < 10; i++)
      drive(1, 1, 0, 64'(100 + i), 0, 1, 0, 64'(200 + i), 0, 64'(i * 3 + 7));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // DMA write alone: no read return.
    drive(1, 0, 0, 0, 0, 1, 1, 64'h8, 64'h1234, 64'hBEEF);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // DMA read granted, then reset before its return is presented.
    drive(1, 0, 0, 0, 0, 1, 0, 64'h18, 0, 64'hCAFE);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // After release the streak must restart from zero.
    for (int i = 0; i < 6; i++)
      drive(1, 1, 1, 64'(300 + i), 64'(i), 1, 1, 64'(400 + i), 64'(i + 50), 0);
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++)
      drive(($urandom % 64) != 0, ($urandom % 4) != 0, $urandom % 2,
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom % 3) != 0, $urandom % 2,
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 64'(cq.size() + crq.size() + drq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: core load/store path (port c, normally high priority) and a DMA/debug loader (port d).
- Sits between the ALU/register-file outputs and the data memory; drives the core stall when the core loses arbitration.
- Single-cycle access: write commits at the granting edge; read data is registered and returned one cycle after grant.
- Starvation of DMA is bounded by a consecutive-grant limit.

Parameters:
- ADDR_W, 64, address width of both requesters and memory.
- DATA_W, 64, data width.
- MAX_BURST, 4, max consecutive core grants while d_req is pending before DMA is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- c_req  in  1  core request; held high until c_gnt.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  core request accepted this cycle.
- c_rvalid  out  1  core read data valid (one cycle after read grant).
- c_rdata  out  DATA_W  core read data.
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  DMA request, same rules as core.
- d_gnt, d_rvalid, d_rdata  out  1/1/DATA_W  DMA grant, read-valid and read-data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  DATA_W  memory combinational read data.
- core_stall  out  1  c_req & ~c_gnt; freezes the PC and pipeline register.

Behaviour:
- Reset (reset=0, async): c_gnt/d_gnt/mem_we/mem_re/c_rvalid/d_rvalid/core_stall = 0. c_rdata/d_rdata = 0. Streak counter = 0. Pending read returns are discarded.
- Grant decision is combinational from the current requests and the registered streak counter. At most one grant per cycle; c_gnt & d_gnt is never 1.
- Winner rules:
  - Only c_req: core wins.
  - Only d_req: DMA wins.
  - Both, streak < MAX_BURST: core wins.
  - Both, streak == MAX_BURST: DMA wins.
- Streak counter, width 4, updates at the clock edge:
  - +1 when the core is granted while d_req = 1.
  - Reset to 0 on any DMA grant, or when d_req = 0.
  - Saturates at MAX_BURST; never wraps.
- Memory port:
  - Driven from the winner: mem_addr, mem_wdata, mem_we = winner we, mem_re = winner ~we.
  - With no grant: mem_addr = 0, mem_wdata = 0, mem_we = 0, mem_re = 0.
- Read return:
  - On a read grant, mem_rdata is registered into the winner's rdata.
  - The winner's rvalid = 1 in the next cycle only; other cycles rvalid = 0.
  - rdata holds its last value when rvalid = 0.
- Write: no rvalid is generated.
- Back-to-back grants to either port are allowed every cycle; a read return and a new grant may coincide.
- A requester dropping req without a grant is legal; no state is kept for it.
- Reset asserted mid-read: the rvalid due next cycle is suppressed.
- Zero-cycle combinational path from req to gnt/mem_*; no path from mem_rdata to any output other than via the register.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt [31:0]: increments each cycle c_req & d_req = 1, wraps 0xFFFFFFFF -> 0, reset to 0.
  - Adds output dma_force_cnt [15:0]: increments when DMA wins due to streak == MAX_BURST, saturates at 0xFFFF.
- Undefined: neither port exists; no counter logic is present.

Test Plan:
- Reset: hold reset=0 with c_req=d_req=1 -> all grants, mem_we, mem_re, rvalid = 0; release reset -> c_gnt=1 the same cycle.
- Core read: c_req=1, c_we=0, c_addr=0x40, mem_rdata=0xDEAD -> c_gnt=1, mem_re=1, mem_addr=0x40; next cycle c_rvalid=1, c_rdata=0xDEAD; cycle after c_rvalid=0.
- Contention with MAX_BURST=4: c_req and d_req held high for 10 cycles -> grant sequence C,C,C,C,D,C,C,C,C,D; core_stall=1 exactly on the D cycles.
- DMA write alone: d_req=1, d_we=1, d_addr=0x8, d_wdata=0x1234 -> d_gnt=1, mem_we=1, mem_wdata=0x1234, d_rvalid stays 0.
- Reset mid-read: DMA read granted, reset=0 before the next edge -> d_rvalid never asserts; streak=0 after release.
- Stats (DMEM_ARB_STATS_EN): the contention scenario above -> conflict_cnt=10, dma_force_cnt=2.
